// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types for the receive-side controller: byte width and mode FSM encodings.
package uart_rx_ctrl_pkg;

   localparam int DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      RXC_OFF   = 2'd0,
      RXC_ON    = 2'd1,
      RXC_FLUSH = 2'd2
   } rxc_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: two-flop synchronizer, stability counter and a one-cycle
// pulse on each accepted rising level. Release is accepted silently.
module btn_debounce #(
   parameter int DEBOUNCE_CLKS = 125000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic press_o
);

   localparam int CW = (DEBOUNCE_CLKS > 1) ? $clog2(DEBOUNCE_CLKS) : 1;

   logic          sync1_q;
   logic          sync2_q;
   logic          level_q;
   logic          level_d;
   logic          level_dly_q;
   logic          press_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Count only while the synchronized level disagrees with the accepted one.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CW'(DEBOUNCE_CLKS - 1)) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         cnt_q       <= '0;
         level_q     <= 1'b0;
         level_dly_q <= 1'b0;
         press_q     <= 1'b0;
      end else begin
         sync1_q     <= btn_i;
         sync2_q     <= sync1_q;
         cnt_q       <= cnt_d;
         level_q     <= level_d;
         level_dly_q <= level_q;
         press_q     <= level_q & ~level_dly_q;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-mode controller: debounced toggle of uart_rx enable, FWFT byte FIFO
// with valid/ready output, sticky overflow, and drain-before-idle on disable.
module uart_rx_ctrl
   import uart_rx_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CLKS = 125000,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                        sysclk,
   input  logic                        i_rst_n,
   input  logic                        i_btn,
   output logic                        o_rx_en,
   input  logic                        i_rx_d,
   input  logic [DATA_WIDTH-1:0]       i_rx_byte,
   output logic [DATA_WIDTH-1:0]       o_data,
   output logic                        o_valid,
   input  logic                        i_ready,
   output logic [$clog2(FIFO_DEPTH):0] o_fill,
   output logic                        o_overflow,
   output logic                        o_busy
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int FW = PW + 1;

   rxc_state_e            state_q;
   rxc_state_e            state_d;
   logic                  press;
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr_q;
   logic [PW-1:0]         rd_ptr_q;
   logic [FW-1:0]         fill_q;
   logic [FW-1:0]         fill_d;
   logic                  overflow_q;
   logic                  overflow_d;
   logic                  valid_q;
   logic                  rx_en_q;
   logic                  busy_q;
   logic                  push_req;
   logic                  pop;
   logic                  full;
   logic                  wr_en;

   btn_debounce #(
      .DEBOUNCE_CLKS (DEBOUNCE_CLKS)
   ) u_debounce (
      .clk_i   (sysclk),
      .rst_ni  (i_rst_n),
      .btn_i   (i_btn),
      .press_o (press)
   );

   assign full     = (fill_q == FW'(FIFO_DEPTH));
   assign push_req = i_rx_d && (state_q == RXC_ON);
   assign pop      = valid_q && i_ready;
   // A full FIFO still takes the byte when the head leaves in the same cycle.
   assign wr_en    = push_req && (!full || pop);

   always_comb begin
      state_d    = state_q;
      overflow_d = overflow_q;
      case (state_q)
         RXC_OFF: begin
            if (press) begin
               state_d    = RXC_ON;
               overflow_d = 1'b0;
            end
         end
         RXC_ON: begin
            if (press) begin
               state_d = RXC_FLUSH;
            end
            if (push_req && full && !pop) begin
               overflow_d = 1'b1;
            end
         end
         RXC_FLUSH: begin
            if (fill_q == '0) begin
               state_d = RXC_OFF;
            end
         end
         default: begin
            state_d = RXC_OFF;
         end
      endcase
   end

   always_comb begin
      fill_d = fill_q;
      case ({wr_en, pop})
         2'b10:   fill_d = fill_q + FW'(1);
         2'b01:   fill_d = fill_q - FW'(1);
         default: fill_d = fill_q;
      endcase
   end

   always_ff @(posedge sysclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= RXC_OFF;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fill_q     <= '0;
         overflow_q <= 1'b0;
         valid_q    <= 1'b0;
         rx_en_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         fill_q     <= fill_d;
         overflow_q <= overflow_d;
         valid_q    <= (fill_d != '0);
         rx_en_q    <= (state_d == RXC_ON);
         busy_q     <= (state_d != RXC_OFF);
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
      end
   end

   // Storage needs no reset: o_data is masked until an entry is valid.
   always_ff @(posedge sysclk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= i_rx_byte;
      end
   end

   assign o_data     = valid_q ? mem_q[rd_ptr_q] : '0;
   assign o_valid    = valid_q;
   assign o_fill     = fill_q;
   assign o_overflow = overflow_q;
   assign o_rx_en    = rx_en_q;
   assign o_busy     = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized bench for uart_rx_ctrl with a queue-based reference model and a
// per-cycle monitor comparing every registered output and each popped byte.
module tb_uart_rx_ctrl;
   import uart_rx_ctrl_pkg::*;

   localparam int DEB   = 8;
   localparam int DEPTH = 4;
   localparam int FW    = $clog2(DEPTH) + 1;

   logic                  clk     = 1'b0;
   logic                  rst_n   = 1'b0;
   logic                  btn     = 1'b0;
   logic                  rx_d    = 1'b0;
   logic                  ready   = 1'b0;
   logic [DATA_WIDTH-1:0] rx_byte = '0;
   logic [DATA_WIDTH-1:0] data;
   logic                  rx_en;
   logic                  valid;
   logic                  overflow;
   logic                  busy;
   logic [FW-1:0]         fill;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   uart_rx_ctrl #(
      .DEBOUNCE_CLKS (DEB),
      .FIFO_DEPTH    (DEPTH)
   ) dut (
      .sysclk     (clk),
      .i_rst_n    (rst_n),
      .i_btn      (btn),
      .o_rx_en    (rx_en),
      .i_rx_d     (rx_d),
      .i_rx_byte  (rx_byte),
      .o_data     (data),
      .o_valid    (valid),
      .i_ready    (ready),
      .o_fill     (fill),
      .o_overflow (overflow),
      .o_busy     (busy)
   );

   function automatic void check(input string name, input int act, input int exp);
      n_checks = n_checks + 1;
      if (act != exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: mode as a plain enum, FIFO as a queue, the button as a
   // run length of raw samples that disagree with the accepted level.
   typedef enum int {M_OFF, M_ON, M_FLUSH} mmode_e;
   mmode_e                m_mode = M_OFF;
   logic [DATA_WIDTH-1:0] m_q[$];
   bit                    m_ovf  = 1'b0;
   bit                    m_acc  = 1'b0;
   int                    m_run  = 0;
   bit   [3:0]            m_pend = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_mode = M_OFF;
         m_q.delete();
         m_ovf  = 1'b0;
         m_acc  = 1'b0;
         m_run  = 0;
         m_pend = '0;
      end else begin
         bit do_pop;
         bit do_push;
         bit do_press;
         bit detect;
         bit flush_done;
         check("fill", int'(fill), m_q.size());
         check("valid", int'(valid), int'(m_q.size() != 0));
         check("overflow", int'(overflow), int'(m_ovf));
         check("rx_en", int'(rx_en), int'(m_mode == M_ON));
         check("busy", int'(busy), int'(m_mode != M_OFF));
         if (valid && m_q.size() != 0) begin
            check("data", int'(data), int'(m_q[0]));
         end

         flush_done = (m_mode == M_FLUSH) && (m_q.size() == 0);
         do_pop     = (m_q.size() != 0) && ready;
         do_push    = rx_d && (m_mode == M_ON);
         if (do_pop) begin
            $display("pop  data=%02h occupancy_before=%0d", m_q[0], m_q.size());
            void'(m_q.pop_front());
         end
         if (do_push) begin
            if (m_q.size() < DEPTH) begin
               m_q.push_back(rx_byte);
            end else begin
               m_ovf = 1'b1;
            end
         end

         // Accepted after DEB disagreeing samples; FSM reacts 4 edges after the last one.
         detect = 1'b0;
         if (btn != m_acc) begin
            m_run = m_run + 1;
            if (m_run == DEB) begin
               m_acc  = btn;
               m_run  = 0;
               detect = btn;
            end
         end else begin
            m_run = 0;
         end
         do_press = m_pend[0];
         m_pend   = m_pend >> 1;
         if (detect) m_pend[3] = 1'b1;

         case (m_mode)
            M_OFF:   if (do_press) begin m_mode = M_ON; m_ovf = 1'b0; end
            M_ON:    if (do_press) m_mode = M_FLUSH;
            M_FLUSH: if (flush_done) m_mode = M_OFF;
            default: m_mode = M_OFF;
         endcase
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press_btn();
      btn = 1'b1;
      step(20);
      btn = 1'b0;
      step(20);
   endtask

   task automatic push(input logic [DATA_WIDTH-1:0] b);
      rx_byte = b;
      rx_d    = 1'b1;
      step(1);
      rx_d    = 1'b0;
      step(1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rx_en"}, int'(rx_en), 0);
      check({tag, "_valid"}, int'(valid), 0);
      check({tag, "_data"}, int'(data), 0);
      check({tag, "_fill"}, int'(fill), 0);
      check({tag, "_overflow"}, int'(overflow), 0);
      check({tag, "_busy"}, int'(busy), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      check_all_zero("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(2);

      // Clean press: edge E is the first posedge sampling btn=1.
      btn = 1'b1;
      step(11);
      check("latency_e10", int'(rx_en), 0);
      step(1);
      check("latency_e11", int'(rx_en), 1);
      step(9);
      btn = 1'b0;
      step(20);
      press_btn();

      // Bouncing 3-cycle glitches, then a real press.
      for (int i = 0; i < 10; i++) begin
         btn = ~btn;
         step(3);
      end
      press_btn();

      // Fill to capacity, then one dropped byte.
      ready = 1'b0;
      for (int i = 0; i < 4; i++) push(8'h41 + 8'(i));
      check("full_fill", int'(fill), 4);
      push(8'h45);
      check("overflow_set", int'(overflow), 1);
      ready = 1'b1;
      step(6);
      ready = 1'b0;

      press_btn();
      press_btn();

      // Full FIFO with simultaneous push and pop.
      for (int i = 0; i < 4; i++) push(8'h60 + 8'(i));
      rx_byte = 8'h55;
      rx_d    = 1'b1;
      ready   = 1'b1;
      step(1);
      rx_d    = 1'b0;
      ready   = 1'b0;
      step(1);
      check("simul_fill", int'(fill), 4);
      check("simul_overflow", int'(overflow), 0);
      ready = 1'b1;
      step(6);
      ready = 1'b0;

      // Disable with two bytes buffered; late byte must be ignored.
      push(8'h71);
      push(8'h72);
      press_btn();
      check("flush_rx_en", int'(rx_en), 0);
      check("flush_busy", int'(busy), 1);
      push(8'h99);
      ready = 1'b1;
      step(6);
      ready = 1'b0;

      // Randomized traffic in ON.
      press_btn();
      for (int i = 0; i < 300; i++) begin
         rx_d    = ($urandom_range(0, 2) == 0);
         rx_byte = 8'($urandom);
         ready   = $urandom_range(0, 1) != 0;
         step(1);
      end
      rx_d  = 1'b0;
      ready = 1'b1;
      step(8);
      ready = 1'b0;
      press_btn();

      // Asynchronous reset in the middle of a flush.
      press_btn();
      for (int i = 0; i < 3; i++) push(8'($urandom));
      press_btn();
      check("preflush_busy", int'(busy), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(2);
      press_btn();
      check("reenter_rx_en", int'(rx_en), 1);
      check("reenter_fill", int'(fill), 0);
      step(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
